// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A-B mod 2^WIDTH, one bit per clock, LSB first.
// Optional signed-overflow output out_ovf enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for in_start; outputs hold last result
  // SHIFT | one full-subtractor step per clock, LSB first
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ar_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d_bit;
  logic             bout;
  logic             last_bit;
  logic             accept;

  assign d_bit    = ar_sh[0] ^ b_sh[0] ^ bin;
  assign bout     = (~ar_sh[0] & b_sh[0]) | (~(ar_sh[0] ^ b_sh[0]) & bin);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    out_busy  = 1'b0;
    out_done  = 1'b0;
    case (state)
      IDLE: begin
        if (in_start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        out_busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_busy  = 1'b1;
        out_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The minuend register doubles as the result register: each consumed
  // LSB frees the MSB slot that the new difference bit shifts into.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      ar_sh      <= '0;
      b_sh       <= '0;
      cnt        <= '0;
      bin        <= 1'b0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      out_ovf    <= 1'b0;
`endif
    end else if (accept) begin
      ar_sh <= in_a;
      b_sh  <= in_b;
      cnt   <= '0;
      bin   <= 1'b0;
    end else if (state == SHIFT) begin
      ar_sh <= {d_bit, ar_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      bin   <= bout;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        out_diff   <= {d_bit, ar_sh[WIDTH-1:1]};
        out_borrow <= bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        out_ovf    <= bin ^ bout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         in_clk = 1'b0;
  logic         in_rst;
  logic         in_start;
  logic [W-1:0] in_a, in_b;
  logic         out_busy, out_done, out_borrow, out_ovf;
  logic [W-1:0] out_diff;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_diff = 0;
  bit prev_borrow = 0;
  bit prev_ovf = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_start  (in_start),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_busy  (out_busy),
    .out_done  (out_done),
    .out_diff  (out_diff),
    .out_borrow(out_borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

`ifndef SERIAL_SUBTRACTOR_OVF_EN
  assign out_ovf = 1'b0;
`endif

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_sub(input int a, input int b, output int diff,
                                    output bit borrow, output bit ovf);
    int sa, sb, r;
    diff   = (a - b) & MASK;
    borrow = (a < b);
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    r  = sa - sb;
    ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  task automatic check_result(input string tag, input int diff, input bit borrow, input bit ovf);
    check({tag, "_diff"}, 32'(out_diff), diff);
    check({tag, "_borrow"}, 32'(out_borrow), 32'(borrow));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
`endif
  endtask

  // One operation; optionally pulses start with FF/FF at loop index poke_j.
  task automatic do_op(input int a, input int b, input int poke_j);
    int diff_e, busy_cnt, done_cnt, done_at;
    bit bor_e, ovf_e;
    model_sub(a, b, diff_e, bor_e, ovf_e);
    @(negedge in_clk);
    in_a = W'(a); in_b = W'(b); in_start = 1'b1;
    @(posedge in_clk);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int j = 0; j <= W + 1; j++) begin
      @(negedge in_clk);
      if (j == 0) begin
        in_start = 1'b0;
        in_a = W'($urandom);
        in_b = W'($urandom);
      end
      if (j == poke_j) begin
        in_start = 1'b1; in_a = '1; in_b = '1;
      end else if (j == poke_j + 1) begin
        in_start = 1'b0;
      end
      if (out_busy) busy_cnt++;
      if (out_done) begin done_cnt++; done_at = j; end
      if (j == W - 1) begin
        check("hold_before_done", 32'(out_diff), prev_diff);
        check("hold_borrow", 32'(out_borrow), 32'(prev_borrow));
      end
      if (j == W) check_result("done", diff_e, bor_e, ovf_e);
    end
    check("done_count", done_cnt, 1);
    check("done_latency", done_at, W);
    check("busy_cycles", busy_cnt, W + 1);
    check_result("hold_after", diff_e, bor_e, ovf_e);
    prev_diff = diff_e; prev_borrow = bor_e; prev_ovf = ovf_e;
  endtask

  initial begin
    int pulses, bad, done_cnt;
    int done_pos[3];
    in_rst = 1'b1; in_start = 1'b0; in_a = '0; in_b = '0;
    #12;
    check("rst_busy", 32'(out_busy), 0);
    check("rst_done", 32'(out_done), 0);
    check_result("rst", 0, 0, 0);
    @(negedge in_clk);
    in_rst = 1'b0;

    do_op(5, 3, -1);
    do_op(3, 5, -1);
    do_op(8'h80, 8'h01, -1);
    do_op(8'h10, 8'h01, 3);
    do_op(8'h5A, 8'h5A, -1);
    do_op(8'hC3, 0, -1);
    do_op(8'h7F, 8'hFF, -1);

    // Reset four cycles into SHIFT.
    @(negedge in_clk);
    in_a = 8'h9C; in_b = 8'h21; in_start = 1'b1;
    @(posedge in_clk);
    @(negedge in_clk);
    in_start = 1'b0;
    repeat (3) @(negedge in_clk);
    #2 in_rst = 1'b1;
    #1;
    check("abort_busy", 32'(out_busy), 0);
    check("abort_done", 32'(out_done), 0);
    check_result("abort", 0, 0, 0);
    done_cnt = 0;
    repeat (2) begin
      @(negedge in_clk);
      if (out_done) done_cnt++;
    end
    in_rst = 1'b0;
    prev_diff = 0; prev_borrow = 0; prev_ovf = 0;
    repeat (10) begin
      @(negedge in_clk);
      if (out_done || out_busy) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    do_op(0, 1, -1);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge in_clk);
    in_a = 8'd7; in_b = 8'd7; in_start = 1'b1;
    @(posedge in_clk);
    pulses = 0; bad = 0;
    for (int j = 0; j < 3 * (W + 2); j++) begin
      @(negedge in_clk);
      if (out_done) begin
        if (pulses < 3) done_pos[pulses] = j;
        pulses++;
        check_result("b2b", 0, 0, 0);
      end
      if (pulses > 0 && out_diff != '0) bad++;
    end
    check("b2b_pulses", pulses, 3);
    check("b2b_first", done_pos[0], W);
    check("b2b_period1", done_pos[1] - done_pos[0], W + 2);
    check("b2b_period2", done_pos[2] - done_pos[1], W + 2);
    check("b2b_stable", bad, 0);
    in_start = 1'b0;
    repeat (W + 3) @(negedge in_clk);
    check("b2b_idle", 32'(out_busy), 0);
    prev_diff = 0; prev_borrow = 0; prev_ovf = 0;

    for (int i = 0; i < 20; i++)
      do_op($urandom_range(0, MASK), $urandom_range(0, MASK), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits; legal range is 2..32.
REQ-002 in_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 in_rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 in_start  input  1  SHALL be the request to start a subtraction; it is sampled only in IDLE.
REQ-005 in_a  input  WIDTH  SHALL be the minuend, captured on the accept edge.
REQ-006 in_b  input  WIDTH  SHALL be the subtrahend, captured on the accept edge.
REQ-007 out_busy  output  1  SHALL be high whenever state != IDLE.
REQ-008 out_done  output  1  SHALL be a one-cycle pulse, high only in DONE.
REQ-009 out_diff  output  WIDTH  SHALL be the registered result A-B mod 2^WIDTH.
REQ-010 out_borrow  output  1  SHALL be the registered final borrow: 1 iff A<B unsigned.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, with in_start=1 at an edge (the accept edge), the block SHALL load in_a and in_b into internal shift registers, clear the borrow flop and the bit counter, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit, LSB first, using a full subtractor: d = a XOR b XOR bin; bout = (~a & b) | (~(a XOR b) & bin).
REQ-014 In SHIFT, the d bit SHALL shift into the MSB of an internal result shift register, and bout SHALL be stored as the next bin.
REQ-015 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL increment once per SHIFT edge.
REQ-016 On the edge that processes bit WIDTH-1, the FSM SHALL enter DONE and SHALL copy the internal result to out_diff and the final bout to out_borrow.
REQ-017 DONE SHALL last exactly one cycle, followed by IDLE unconditionally.
REQ-018 Latency SHALL be: accept edge k; DONE state (and out_done) during the cycle after edge k+WIDTH; total WIDTH+1 cycles from the accept edge.
REQ-019 out_diff and out_borrow SHALL change only on entry to DONE and SHALL hold their values through IDLE until the next completion.
REQ-020 in_start SHALL be ignored in SHIFT and DONE, and in_a/in_b changes after the accept edge SHALL have no effect on the current operation.
REQ-021 in_start held high continuously SHALL yield back-to-back operations; the next accept edge is the first edge in IDLE after DONE.
REQ-022 The no-borrow cases SHALL behave as follows: A=B gives diff=0 and borrow=0; B=0 gives diff=A and borrow=0.

Reset
REQ-023 Asserting in_rst SHALL immediately force state=IDLE, counter=0, internal registers=0, out_busy=0, out_done=0, out_diff=0, out_borrow=0 (and out_ovf=0 when present).
REQ-024 Reset asserted during SHIFT SHALL abort the operation without producing any done pulse.
REQ-025 The first accept edge after reset deassertion SHALL be honoured normally.

Configuration
REQ-026 Macro SERIAL_SUBTRACTOR_OVF_EN, when defined, SHALL add the port out_ovf  output  1, the registered two's-complement signed overflow, equal to (borrow into MSB) XOR (borrow out of MSB).
REQ-027 out_ovf SHALL be updated with the same timing and hold rules as out_borrow.
REQ-028 Without SERIAL_SUBTRACTOR_OVF_EN, out_ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-029 Test 1: a=5, b=3, start pulse -> out_done high exactly 9 cycles after the accept edge; diff=0x02, borrow=0, ovf=0; busy high for 9 cycles.
REQ-030 Test 2: a=3, b=5 -> diff=0xFE, borrow=1, ovf=0.
REQ-031 Test 3: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1 (macro on); without the macro there is no out_ovf port and diff/borrow are unchanged.
REQ-032 Test 4: a=0x10, b=0x01 accepted, then start with a=0xFF, b=0xFF pulsed during SHIFT -> a single done pulse with diff=0x0F; no second operation.
REQ-033 Test 5: in_rst asserted 4 cycles into SHIFT -> all outputs 0 at once, no done pulse; next op a=0, b=1 -> diff=0xFF, borrow=1.
REQ-034 Test 6: start held high with a=7, b=7 -> done pulses every 10 cycles, each with diff=0x00 and borrow=0, and out_diff stable between pulses.
